uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Parametrised UART transmitter for the response path: accepts bytes from the command dispatcher side into an internal FIFO and serialises them onto the `tx` line. It generates its own bit timing from a clock/baud divisor, so no external `baud_tick` is needed. Data width, parity mode, stop-bit count and FIFO depth are configurable, and back-to-back frames are sent with no idle gap. It replaces the fixed 8N1 transmitter plus external baud generator in the host-link datapath.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate; `DIV = (CLK_HZ + BAUD/2) / BAUD` cycles per bit; elaboration error if `DIV < 2`.
- `DATA_BITS`, 8: data bits per frame, legal 5..9; other values are an elaboration error.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: legal 1 or 2.
- `FIFO_DEPTH`, 16: power of two, ≥ 2.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: push `wr_data` into the FIFO this cycle.
- `wr_data` in DATA_BITS: byte to transmit.
- `full` out 1: FIFO holds FIFO_DEPTH entries.
- `empty` out 1: FIFO holds 0 entries.
- `level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: one-cycle pulse when a write is dropped.
- `busy` out 1: FSM not in IDLE.
- `tx` out 1: serial line, idle high, registered.

## Operation
- Reset values: `tx`=1, `full`=0, `empty`=1, `level`=0, `overflow`=0, `busy`=0. FIFO pointers are cleared and the FSM is in IDLE.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronously). Queued and in-flight data is discarded.
- FIFO write: `wr_en` with `full`=0 stores `wr_data`. `wr_en` with `full`=1 drops the data and pulses `overflow` for one cycle.
  - `full` is evaluated before the edge. A write to a full FIFO is dropped even if the FSM pops in the same cycle.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. `level` is updated every cycle: +1 for an accepted write, −1 for a pop, unchanged when both occur.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, set `tx`=0 and go to START.
  - START: hold for DIV cycles, then go to DATA with `tx` = bit 0.
  - DATA: shift LSB first, each bit held for DIV cycles. After bit DATA_BITS−1, go to PARITY if `PARITY`≠0, otherwise to STOP.
  - PARITY: the bit is `^data` for even parity and `~^data` for odd parity (so the total count of ones including parity is even or odd, respectively). Hold DIV cycles, then go to STOP.
  - STOP: `tx`=1 for STOP_BITS×DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- The bit counter is `$clog2(DIV)` bits and reloads at every bit boundary. The data bit index is a 4-bit counter.
- `busy` = 1 in all states except IDLE.

## Timing
- Write latency: `wr_en` sampled at edge N into an empty FIFO with the FSM in IDLE → pop and `tx` falling at edge N+1. `empty` and `level` reflect the write after edge N.
- Frame length: exactly `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × DIV` cycles, measured from falling edge to the next possible falling edge.
- Every bit lasts exactly DIV cycles, with no drift across back-to-back frames.
- `full`, `empty`, `level` and `overflow` are registered and valid one cycle after the causing edge.

## Test plan
- Bench parameters: CLK_HZ=1_000_000, BAUD=100_000 (DIV=10), 8N1, depth 4. Write 0xA5 → `tx` low at edge N+1 for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles; `busy` cleared 100 cycles after the start.
- 8E2: write 0x07 → parity bit 1, two stop bits, frame 120 cycles. 8O1: write 0x07 → parity bit 0, frame 110 cycles.
- DATA_BITS=5: write 0x1F → only 5 data bits of 1 are transmitted; frame 70 cycles.
- Depth 4: five writes in consecutive cycles while IDLE → the first pops immediately, four fit in the FIFO, and no `overflow` pulse. Write to a full FIFO → `overflow` pulses once, `level` stays 4, and the dropped byte never appears on `tx`. The FIFO drains with each START immediately after the previous STOP, no idle gap.
- Assert `rst` 35 cycles into a frame → `tx`=1 asynchronously, `level`=0, `busy`=0. After deassertion, a new write of 0x3C is transmitted correctly from the start bit.
- Simultaneous `wr_en` and pop with `level`=2 → `level` stays 2 and byte order is preserved on `tx`.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with an internal write FIFO.
// Bit timing is derived from CLK_HZ/BAUD; frames are sent back to back
// whenever the FIFO still holds data at the end of a stop bit.
module uart_tx_cfg #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [DATA_BITS-1:0]          wr_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          busy,
   output logic                          tx
);

   localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;

   localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   // Reject illegal configurations at elaboration time.
   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_cfg: DIV must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state;
   logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [LW-1:0]         level_nxt;
   logic [DATA_BITS-1:0]  head;
   logic [DATA_BITS-1:0]  shreg;
   logic                  par_bit;
   logic [CW-1:0]         cnt;
   logic [3:0]            idx;
   logic                  bit_end;
   logic                  push;
   logic                  pop;

   // full is the registered flag, so a write to a full FIFO is dropped even
   // if the transmitter pops in the same cycle.
   assign push    = wr_en && !full;
   assign bit_end = (cnt == '0);
   assign head    = mem[rd_ptr];
   assign pop     = !empty && ((state == S_IDLE) ||
                               (state == S_STOP && bit_end && idx == STOP_LAST));

   // Next occupancy: a simultaneous push and pop leaves the level unchanged.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      level_nxt = level;
      if (push && !pop) begin
         level_nxt = level + LW'(1);
      end else if (pop && !push) begin
         level_nxt = level - LW'(1);
      end
   end

   // FIFO storage write port.
   // NOTE: the data array has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers and registered status flags.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         level    <= level_nxt;
         full     <= (level_nxt == LW'(FIFO_DEPTH));
         empty    <= (level_nxt == '0);
         overflow <= wr_en && full;
      end
   end

   // Frame sequencer: start, data (LSB first), optional parity, stop bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         tx      <= 1'b1;
         busy    <= 1'b0;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  shreg   <= head;
                  par_bit <= (PARITY == 2) ? ^head : ~^head;
                  tx      <= 1'b0;
                  cnt     <= DIV_M1;
                  busy    <= 1'b1;
                  state   <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
                  idx   <= '0;
                  cnt   <= DIV_M1;
                  state <= S_DATA;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  cnt <= DIV_M1;
                  if (idx == DATA_LAST) begin
                     idx <= '0;
                     if (PARITY != 0) begin
                        tx    <= par_bit;
                        state <= S_PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                     end
                  end else begin
                     tx    <= shreg[0];
                     shreg <= shreg >> 1;
                     idx   <= idx + 4'd1;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  tx    <= 1'b1;
                  idx   <= '0;
                  cnt   <= DIV_M1;
                  state <= S_STOP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  cnt <= DIV_M1;
                  if (idx != STOP_LAST) begin
                     idx <= idx + 4'd1;
                  end else if (pop) begin
                     shreg   <= head;
                     par_bit <= (PARITY == 2) ? ^head : ~^head;
                     tx      <= 1'b0;
                     state   <= S_START;
                  end else begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: four transmitter configurations (8N1, 8E2, 8O1, 5N1, all
// DIV=10, depth 4) run in parallel. Each stimulus process pushes expected
// frames (start cycle + line bits) into a scoreboard; a monitor per instance
// pops an entry on every falling edge of tx and checks the whole frame.
module tb_uart_tx_cfg;

   localparam int NCFG    = 4;
   localparam int CLK_HZ  = 1_000_000;
   localparam int BAUD    = 100_000;
   localparam int DIV     = 10;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 40_000;

   function automatic int db_of(input int g);
      return (g == 3) ? 5 : 8;
   endfunction
   function automatic int par_of(input int g);
      return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
   endfunction
   function automatic int sb_of(input int g);
      return (g == 1) ? 2 : 1;
   endfunction
   function automatic int dir_byte(input int g);
      return (g == 0) ? 'hA5 : ((g == 3) ? 'h1F : 'h07);
   endfunction

   logic        clk = 1'b0;
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;

   always #5 clk = ~clk;

   // Count rising edges; read at falling edges it names the last edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int DB    = db_of(g);
      localparam int PAR   = par_of(g);
      localparam int SB    = sb_of(g);
      localparam int FB    = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
      localparam int FRAME = FB * DIV;

      logic                     rst;
      logic                     wr_en;
      logic [DB-1:0]            wr_data;
      logic                     full;
      logic                     empty;
      logic [$clog2(DEPTH):0]   level;
      logic                     overflow;
      logic                     busy;
      logic                     tx;

      uart_tx_cfg #(
         .CLK_HZ    (CLK_HZ),
         .BAUD      (BAUD),
         .DATA_BITS (DB),
         .PARITY    (PAR),
         .STOP_BITS (SB),
         .FIFO_DEPTH(DEPTH)
      ) dut (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wr_en),
         .wr_data (wr_data),
         .full    (full),
         .empty   (empty),
         .level   (level),
         .overflow(overflow),
         .busy    (busy),
         .tx      (tx)
      );

      // Scoreboard of expected frames and the model's view of queued bytes.
      int unsigned exp_start [$];
      logic [15:0] exp_bits  [$];
      int unsigned pend      [$];
      int unsigned last_start = 0;
      bit          any = 1'b0;

      // Line bits of one frame, index 0 = start bit; unused upper bits are 1.
      function automatic logic [15:0] frame_bits(input logic [DB-1:0] d);
         logic [15:0] b;
         int          ones;
         b    = '1;
         b[0] = 1'b0;
         ones = 0;
         for (int i = 0; i < DB; i++) begin
            b[1+i] = d[i];
            ones  += int'(d[i]);
         end
         if (PAR == 2) b[1+DB] = (ones % 2 == 1);
         if (PAR == 1) b[1+DB] = (ones % 2 == 0);
         return b;
      endfunction

      // One write cycle: model decides accept/drop, start time and level.
      task automatic wr(input logic [DB-1:0] d);
         int unsigned n;
         int unsigned s;
         int          lvl;
         bit          drop;
         n       = cyc + 1;
         wr_en   = 1'b1;
         wr_data = d;
         while (pend.size() > 0 && pend[0] < n) void'(pend.pop_front());
         drop = (pend.size() == DEPTH);
         if (!drop) begin
            s = (any && last_start + FRAME > n + 1) ? last_start + FRAME : n + 1;
            pend.push_back(s);
            last_start = s;
            any        = 1'b1;
            exp_start.push_back(s);
            exp_bits.push_back(frame_bits(d));
         end
         lvl = 0;
         foreach (pend[i]) if (pend[i] > n) lvl++;
         @(negedge clk);
         wr_en = 1'b0;
         check($sformatf("cfg%0d overflow", g), overflow, drop);
         check($sformatf("cfg%0d level", g), level, lvl);
         check($sformatf("cfg%0d full", g), full, (lvl == DEPTH));
         check($sformatf("cfg%0d empty", g), empty, (lvl == 0));
      endtask

      task automatic idle(input int n);
         wr_en = 1'b0;
         repeat (n) @(negedge clk);
      endtask

      task automatic drain();
         for (int k = 0; k < 20 * FRAME && exp_start.size() != 0; k++) @(negedge clk);
         repeat (FRAME + 2) @(negedge clk);
         check($sformatf("cfg%0d frames outstanding", g), exp_start.size(), 0);
         check($sformatf("cfg%0d busy after drain", g), busy, 1'b0);
         check($sformatf("cfg%0d tx idle", g), tx, 1'b1);
         check($sformatf("cfg%0d level after drain", g), level, 0);
      endtask

      // Monitor: each falling edge of tx consumes one expected frame.
      initial begin : mon
         int unsigned s;
         logic [15:0] b;
         logic [15:0] got;
         bit          stable;
         bit          aborted;
         forever begin
            @(negedge clk);
            if (rst) continue;
            if (tx === 1'b0) begin
               check($sformatf("cfg%0d frame expected", g), (exp_start.size() != 0), 1'b1);
               if (exp_start.size() == 0) begin
                  repeat (FRAME - 1) @(negedge clk);
               end else begin
                  s       = exp_start.pop_front();
                  b       = exp_bits.pop_front();
                  got     = '1;
                  stable  = 1'b1;
                  aborted = 1'b0;
                  check($sformatf("cfg%0d start cycle", g), cyc, s);
                  for (int k = 0; k < FRAME; k++) begin
                     if (k > 0) @(negedge clk);
                     if (rst) begin
                        aborted = 1'b1;
                        break;
                     end
                     if (k % DIV == DIV / 2) got[k/DIV] = tx;
                     if (tx !== b[k/DIV]) stable = 1'b0;
                  end
                  if (!aborted) begin
                     check($sformatf("cfg%0d frame bits", g), got, b);
                     check($sformatf("cfg%0d bit timing", g), stable, 1'b1);
                  end
               end
            end
         end
      end

      // Stimulus for this configuration.
      initial begin : stim
         int unsigned s;
         rst     = 1'b0;
         wr_en   = 1'b0;
         wr_data = '0;
         #1 rst = 1'b1;
         #1;
         check($sformatf("cfg%0d reset tx", g), tx, 1'b1);
         check($sformatf("cfg%0d reset full", g), full, 1'b0);
         check($sformatf("cfg%0d reset empty", g), empty, 1'b1);
         check($sformatf("cfg%0d reset level", g), level, 0);
         check($sformatf("cfg%0d reset overflow", g), overflow, 1'b0);
         check($sformatf("cfg%0d reset busy", g), busy, 1'b0);
         @(negedge clk);
         #1 rst = 1'b0;
         @(negedge clk);

         // Single directed frame, busy drops exactly at frame end.
         wr(DB'(dir_byte(g)));
         s = last_start;
         repeat (s + FRAME - 1 - cyc) @(negedge clk);
         check($sformatf("cfg%0d busy last cycle", g), busy, 1'b1);
         @(negedge clk);
         check($sformatf("cfg%0d busy after frame", g), busy, 1'b0);
         idle(3);

         // Five writes fill FIFO (first pops at once), sixth overflows.
         for (int i = 0; i < 5; i++) wr(DB'($urandom));
         wr(DB'(8'hEE));
         drain();

         // Reset 35 cycles into a frame of zeros, then a clean frame.
         wr('0);
         s = last_start;
         repeat (s + 34 - cyc) @(negedge clk);
         check($sformatf("cfg%0d tx low before reset", g), tx, 1'b0);
         #1 rst = 1'b1;
         #1;
         check($sformatf("cfg%0d async reset tx", g), tx, 1'b1);
         check($sformatf("cfg%0d async reset level", g), level, 0);
         check($sformatf("cfg%0d async reset busy", g), busy, 1'b0);
         exp_start.delete();
         exp_bits.delete();
         pend.delete();
         any = 1'b0;
         repeat (2) @(negedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         wr(DB'(8'h3C));
         drain();

         // Random traffic: heavy bursts then sparse writes.
         for (int i = 0; i < 250; i++) begin
            if ($urandom_range(3) == 0) wr(DB'($urandom));
            else idle(1);
         end
         for (int i = 0; i < 800; i++) begin
            if ($urandom_range(49) == 0) wr(DB'($urandom));
            else idle(1);
         end
         drain();
         done_cnt++;
      end
   end

   initial begin : top
      fork
         wait (done_cnt == NCFG);
         repeat (TIMEOUT) @(posedge clk);
      join_any
      disable fork;
      check("all configurations completed", done_cnt, NCFG);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
